// File: rtl/spad_fill_pkg.sv
// spad_fill_pkg: shared definitions for the activation scratchpad fill sequencer.
//   Contents: fill FSM state encoding, the word-width and depth defaults shared
//   with the scratchpad, and the burst-length clamp helper.
package spad_fill_pkg;

  // Defaults that must track the scratchpad instance.
  localparam int SPAD_DATA_DW = 12;
  localparam int SPAD_DEPTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fill_state_e;

  // A burst can never be longer than the scratchpad, so oversize requests are
  // truncated to a full fill instead of wrapping the write address.
  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/spad_fill_pipe.sv
// spad_fill_pipe: read-to-write pipeline of the scratchpad fill sequencer.
//   Ports: clk/rst; clr restarts the write counter; rd_vld is the registered
//   SRAM read enable, rd_dat the SRAM read data one cycle later; outputs are
//   the registered scratchpad write port (we_en/addr_we/wr_dat) and the
//   number of words written so far (written).
module spad_fill_pipe
  import spad_fill_pkg::*;
#(
  parameter int DATA_DW = SPAD_DATA_DW,
  parameter int DEPTH   = SPAD_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         rd_vld,
  input  logic [DATA_DW-1:0]           rd_dat,
  output logic                         we_en,
  output logic [$clog2(DEPTH)-1:0]     addr_we,
  output logic [DATA_DW-1:0]           wr_dat,
  output logic [$clog2(DEPTH+1)-1:0]   written
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic          re_d1_q,   re_d1_d;
  logic          we_en_q,   we_en_d;
  logic [AW-1:0] addr_we_q, addr_we_d;
  logic [DATA_DW-1:0] wr_dat_q, wr_dat_d;
  logic [LW-1:0] written_q, written_d;

  // re_d1 marks the cycle in which rd_dat holds the word requested by the
  // previous cycle's read; capturing it here puts the write one cycle later,
  // i.e. two cycles after the read was presented.
  always_comb begin
    re_d1_d   = rd_vld;
    we_en_d   = 1'b0;
    addr_we_d = addr_we_q;
    wr_dat_d  = wr_dat_q;
    written_d = written_q;
    if (clr) begin
      written_d = '0;
    end else if (re_d1_q) begin
      we_en_d   = 1'b1;
      wr_dat_d  = rd_dat;
      addr_we_d = written_q[AW-1:0];
      written_d = written_q + LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_d1_q   <= 1'b0;
      we_en_q   <= 1'b0;
      addr_we_q <= '0;
      wr_dat_q  <= '0;
      written_q <= '0;
    end else begin
      re_d1_q   <= re_d1_d;
      we_en_q   <= we_en_d;
      addr_we_q <= addr_we_d;
      wr_dat_q  <= wr_dat_d;
      written_q <= written_d;
    end
  end

  assign we_en   = we_en_q;
  assign addr_we = addr_we_q;
  assign wr_dat  = wr_dat_q;
  assign written = written_q;

endmodule

// File: rtl/spad_fill_ctrl.sv
// spad_fill_ctrl: fills the per-PE activation scratchpad from the activation
//   SRAM, one word per cycle, on a start pulse. Ports: start/base_addr/len
//   request a burst; pause throttles reads; sram_re/sram_addr/sram_rdata is
//   the SRAM read port; is_sram_in/we_en/addr_we/sram_data_in is the
//   scratchpad write port; busy/done report progress to the layer controller.
module spad_fill_ctrl
  import spad_fill_pkg::*;
#(
  parameter int DATA_DW = SPAD_DATA_DW,
  parameter int DEPTH   = SPAD_DEPTH,
  parameter int SRAM_AW = 10
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [SRAM_AW-1:0]           base_addr,
  input  logic [$clog2(DEPTH+1)-1:0]   len,
  input  logic                         sram_mode,
  input  logic                         pause,
  output logic                         sram_re,
  output logic [SRAM_AW-1:0]           sram_addr,
  input  logic [DATA_DW-1:0]           sram_rdata,
  output logic                         is_sram_in,
  output logic                         we_en,
  output logic [$clog2(DEPTH)-1:0]     addr_we,
  output logic [DATA_DW-1:0]           sram_data_in,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(DEPTH+1);

  fill_state_e        state_q,     state_d;
  logic [SRAM_AW-1:0] base_q,      base_d;
  logic [LW-1:0]      len_q,       len_d;
  logic [LW-1:0]      issued_q,    issued_d;
  logic               sram_re_q,   sram_re_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  logic               pipe_clr;
  logic [LW-1:0]      written;
  logic [LW-1:0]      issued_inc;

  assign issued_inc = issued_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    sram_re_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pipe_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (len != '0) begin
            base_d   = base_addr;
            len_d    = LW'(clamp_len(32'(len), DEPTH));
            issued_d = '0;
            pipe_clr = 1'b1;
            busy_d   = 1'b1;
            state_d  = READ;
          end else begin
            // Empty burst: report completion without touching either memory.
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end

      READ: begin
        if (!pause && (issued_q < len_q)) begin
          sram_re_d   = 1'b1;
          // Address arithmetic is modulo the SRAM size; wrap is intentional.
          sram_addr_d = base_q + SRAM_AW'(issued_q);
          issued_d    = issued_inc;
          if (issued_inc == len_q) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // written reaches len in the same cycle the last write is presented,
        // so leaving here keeps that write visible for its full cycle.
        if (written == len_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      sram_re_q   <= 1'b0;
      sram_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      sram_re_q   <= sram_re_d;
      sram_addr_q <= sram_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  spad_fill_pipe #(
    .DATA_DW (DATA_DW),
    .DEPTH   (DEPTH)
  ) u_pipe (
    .clk     (sclk),
    .rst     (rst),
    .clr     (pipe_clr),
    .rd_vld  (sram_re_q),
    .rd_dat  (sram_rdata),
    .we_en   (we_en),
    .addr_we (addr_we),
    .wr_dat  (sram_data_in),
    .written (written)
  );

  assign sram_re    = sram_re_q;
  assign sram_addr  = sram_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  // Combinational on purpose: the scratchpad must see SRAM-load mode from the
  // first cycle of busy, and it samples on negedge so there is setup margin.
  assign is_sram_in = sram_mode | busy_q;

endmodule

// File: tb/tb_spad_fill_ctrl.sv
module tb_spad_fill_ctrl;

  logic        sclk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [3:0]  len;
  logic        sram_mode;
  logic        pause;
  logic        sram_re;
  logic [9:0]  sram_addr;
  logic [11:0] sram_rdata;
  logic        is_sram_in;
  logic        we_en;
  logic [2:0]  addr_we;
  logic [11:0] sram_data_in;
  logic        busy;
  logic        done;

  spad_fill_ctrl #(.DATA_DW(12), .DEPTH(8), .SRAM_AW(10)) dut (
    .sclk         (sclk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .sram_mode    (sram_mode),
    .pause        (pause),
    .sram_re      (sram_re),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .is_sram_in   (is_sram_in),
    .we_en        (we_en),
    .addr_we      (addr_we),
    .sram_data_in (sram_data_in),
    .busy         (busy),
    .done         (done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // SRAM contents: word at address a is 0x100 + (a - 0x010), mod 2^12.
  function automatic logic [11:0] word_of(input logic [9:0] a);
    return 12'(int'(a) - 16 + 256);
  endfunction

  // Synchronous-read SRAM: data appears the cycle after sram_re.
  always @(posedge sclk) begin
    if (sram_re) sram_rdata <= word_of(sram_addr);
  end

  // Event log sampled on negedge, where the scratchpad samples too.
  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  int          wr_addr_q[$];
  int          wr_dat_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  logic [11:0] spad [8];

  always @(negedge sclk) begin
    if (!rst) begin
      if (sram_re) begin rd_addr_q.push_back(int'(sram_addr)); rd_cyc_q.push_back(cyc); end
      if (we_en) begin
        wr_addr_q.push_back(int'(addr_we));
        wr_dat_q.push_back(int'(sram_data_in));
        wr_cyc_q.push_back(cyc);
        spad[addr_we] <= sram_data_in;
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_log();
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  // Issue one burst and wait for done (bounded). pause is held for pc
  // edges starting at the edge after the pa-th read would have issued.
  task automatic do_burst(input logic [9:0] b, input logic [3:0] l,
                          input int pa, input int pc,
                          output int c0, output bit got);
    clear_log();
    got = 1'b0;
    @(negedge sclk);
    c0 = cyc; start = 1'b1; base_addr = b; len = l;
    @(negedge sclk);
    start = 1'b0; base_addr = 10'h2AA; len = 4'd3;  // mid-burst changes must not matter
    for (int e = 0; e < 60; e++) begin
      if (done) begin got = 1'b1; break; end
      pause = ((e + 1) >= (pa + 1)) && ((e + 1) <= (pa + pc));
      @(negedge sclk);
    end
    pause = 1'b0;
    repeat (3) @(negedge sclk);
    #1;
  endtask

  typedef struct {
    logic [9:0] base;
    logic [3:0] len;
    int         pause_at;
    int         pause_len;
    int         exp_n;
    int         exp_lat;   // edges from accepting edge to the edge that raises done
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  c0;
    bit  got;
    int  n;
    int  wcnt;
    bit  seen;

    vecs[0] = '{10'h010, 4'd8,  99, 0, 8, 11};   // basic full burst
    vecs[1] = '{10'h020, 4'd4,  2,  2, 4, 9};    // 2-cycle pause after 2nd read
    vecs[2] = '{10'h030, 4'd0,  99, 0, 0, 0};    // empty burst
    vecs[3] = '{10'h040, 4'd15, 99, 0, 8, 11};   // clamped to depth
    vecs[4] = '{10'h3FE, 4'd4,  99, 0, 4, 7};    // SRAM address wrap
    vecs[5] = '{10'h100, 4'd1,  99, 0, 1, 4};    // single word

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    sram_mode = 1'b0; pause = 1'b0; sram_rdata = '0;
    for (int k = 0; k < 8; k++) spad[k] = 12'hFFF;

    #12;
    chk("rst_sram_re", int'(sram_re), 0);
    chk("rst_we_en", int'(we_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addrs", int'({sram_addr, addr_we}), 0);
    chk("rst_wdata", int'(sram_data_in), 0);
    chk("rst_is_sram_in", int'(is_sram_in), 0);
    sram_mode = 1'b1;
    #1;
    chk("mode1_is_sram_in", int'(is_sram_in), 1);
    sram_mode = 1'b0;
    @(negedge sclk); rst = 1'b0;
    repeat (2) @(negedge sclk);

    for (int i = 0; i < 6; i++) begin
      do_burst(vecs[i].base, vecs[i].len, vecs[i].pause_at, vecs[i].pause_len, c0, got);
      chk($sformatf("v%0d_done_seen", i), int'(got), 1);
      chk($sformatf("v%0d_done_count", i), done_cyc_q.size(), 1);
      if (done_cyc_q.size() > 0)
        chk($sformatf("v%0d_latency", i), done_cyc_q[0] - (c0 + 1), vecs[i].exp_lat);
      chk($sformatf("v%0d_reads", i), rd_addr_q.size(), vecs[i].exp_n);
      chk($sformatf("v%0d_writes", i), wr_addr_q.size(), vecs[i].exp_n);
      n = (rd_addr_q.size() < vecs[i].exp_n) ? rd_addr_q.size() : vecs[i].exp_n;
      for (int k = 0; k < n; k++) begin
        chk($sformatf("v%0d_rd_addr%0d", i, k), rd_addr_q[k],
            int'(10'(vecs[i].base + 10'(k))));
        chk($sformatf("v%0d_rd_cyc%0d", i, k), rd_cyc_q[k] - c0,
            2 + k + ((k >= vecs[i].pause_at) ? vecs[i].pause_len : 0));
      end
      n = (wr_addr_q.size() < vecs[i].exp_n) ? wr_addr_q.size() : vecs[i].exp_n;
      for (int k = 0; k < n; k++) begin
        chk($sformatf("v%0d_wr_addr%0d", i, k), wr_addr_q[k], k);
        chk($sformatf("v%0d_wr_dat%0d", i, k), wr_dat_q[k],
            int'(word_of(10'(vecs[i].base + 10'(k)))));
        if (k < rd_cyc_q.size())
          chk($sformatf("v%0d_wr_lag%0d", i, k), wr_cyc_q[k] - rd_cyc_q[k], 2);
      end
      if (i == 0) begin
        for (int k = 0; k < 8; k++)
          chk($sformatf("spad_readback%0d", k), int'(spad[k]), 12'h100 + k);
      end
    end

    // Start pulsed mid-burst is ignored; is_sram_in follows busy with mode=0.
    clear_log();
    seen = 1'b0;
    @(negedge sclk); start = 1'b1; base_addr = 10'h080; len = 4'd4;
    @(negedge sclk); start = 1'b0;
    @(negedge sclk); start = 1'b1; base_addr = 10'h090; len = 4'd8;
    chk("mid_is_sram_in", int'(is_sram_in), 1);
    chk("mid_busy", int'(busy), 1);
    @(negedge sclk); start = 1'b0;
    for (int e = 0; e < 40; e++) begin
      if (done) begin
        seen = 1'b1;
        chk("fin_busy_low", int'(busy), 0);
        break;
      end
      @(negedge sclk);
    end
    chk("ign_done_seen", int'(seen), 1);
    repeat (3) @(negedge sclk);
    #1;
    chk("ign_writes", wr_addr_q.size(), 4);
    chk("ign_done_count", done_cyc_q.size(), 1);
    chk("idle_is_sram_in", int'(is_sram_in), 0);

    // Reset after 3 writes of an 8-word burst aborts with no done.
    clear_log();
    wcnt = 0;
    @(negedge sclk); start = 1'b1; base_addr = 10'h050; len = 4'd8;
    @(negedge sclk); start = 1'b0;
    for (int e = 0; e < 40; e++) begin
      if (we_en) wcnt++;
      if (wcnt == 3) break;
      @(negedge sclk);
    end
    chk("abort_reached_3", wcnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_sram_re", int'(sram_re), 0);
    chk("abort_we_en", int'(we_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_outs", int'({sram_addr, addr_we, sram_data_in}), 0);
    chk("abort_is_sram_in", int'(is_sram_in), 0);
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    repeat (12) @(negedge sclk);
    #1;
    chk("abort_no_done", done_cyc_q.size(), 0);
    chk("abort_no_more_writes", wr_addr_q.size(), 3);

    do_burst(10'h060, 4'd2, 99, 0, c0, got);
    chk("post_rst_done", int'(got), 1);
    chk("post_rst_writes", wr_addr_q.size(), 2);
    if (done_cyc_q.size() > 0) chk("post_rst_latency", done_cyc_q[0] - (c0 + 1), 5);
    if (wr_dat_q.size() == 2) begin
      chk("post_rst_dat0", wr_dat_q[0], int'(word_of(10'h060)));
      chk("post_rst_dat1", wr_dat_q[1], int'(word_of(10'h061)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
